// File: rtl/keypad_pkg.sv
// Shared keypad types and tables: key map, column drive patterns, keycode layout and scan states.
// Keycodes are {pressed, hex}; the all-zero code means "no key".
package keypad_pkg;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int HEX_W  = 4;
  localparam int CODE_W = HEX_W + 1;

  typedef struct packed {
    logic              pressed;
    logic [HEX_W-1:0]  hex;
  } key_t;

  localparam key_t KEY_NONE = '0;

  // Indexed by {row, col}: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = 0 F E D
  localparam logic [HEX_W-1:0] KEYMAP [0:15] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  localparam logic [COLS-1:0] COL_SEL [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_EVAL
  } scan_state_t;
endpackage

// File: rtl/keypad_debounce.sv
// Accepts a per-scan candidate once it repeats for DEBOUNCE_SCANS scans; latency 1 cycle after eval.
// No backpressure: key_strobe is a single-cycle pulse on each newly accepted key.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              eval,
  input  logic [CODE_W-1:0] cand,
  output logic [CODE_W-1:0] key_code,
  output logic              key_strobe
);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  key_t          cand_k;
  key_t          prev_cand;
  key_t          stable;
  key_t          code_q;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          accept;

  assign cand_k = key_t'(cand);

  always_comb begin
    cnt_nxt = CW'(1);
    if (cand_k == prev_cand) begin
      cnt_nxt = (match_cnt == CNT_MAX) ? CNT_MAX : match_cnt + 1'b1;
    end
    accept = eval && (cnt_nxt == CNT_MAX) && (cand_k != stable);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cand  <= KEY_NONE;
      match_cnt  <= '0;
      stable     <= KEY_NONE;
      code_q     <= KEY_NONE;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= accept && cand_k.pressed;
      if (eval) begin
        prev_cand <= cand_k;
        match_cnt <= cnt_nxt;
      end
      if (accept) begin
        stable <= cand_k;
        // A release keeps the last hex digit visible for the CPU register
        if (cand_k.pressed) begin
          code_q <= cand_k;
        end else begin
          code_q.pressed <= 1'b0;
        end
      end
    end
  end

  assign key_code = code_q;
endmodule

// File: rtl/keypad_scanner.sv
// Walks the 4x4 keypad columns, samples synchronised rows, hands one candidate per scan to the debouncer.
// Press latency up to (DEBOUNCE_SCANS+1)*4*COL_TICKS+3 cycles; no backpressure, free-running scan.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int COL_TICKS      = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_strobe
);
  localparam int TW = $clog2(COL_TICKS);
  localparam logic [TW-1:0] TICK_PRE = TW'(COL_TICKS - 2);

  scan_state_t     state, state_nxt;
  logic [TW-1:0]   tick, tick_nxt;
  logic [1:0]      col_idx, col_idx_nxt;
  logic [1:0]      rst_pipe;
  logic            run;
  logic [ROWS-1:0] row_meta, row_sync;
  logic            sample_en, eval_en;
  logic            hit;
  logic [1:0]      hit_row;
  key_t            cand;

  // Reset asserts asynchronously but the scan only starts two clocks after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= '0;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end
  assign run = rst_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // IDLE and EVAL both count as tick 0 of column 0, so every column lasts COL_TICKS cycles
  always_comb begin
    state_nxt   = state;
    tick_nxt    = tick;
    col_idx_nxt = col_idx;
    sample_en   = 1'b0;
    eval_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) begin
          state_nxt = ST_DRIVE;
          tick_nxt  = TW'(1);
        end
      end
      ST_DRIVE: begin
        tick_nxt = tick + 1'b1;
        if (tick == TICK_PRE) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        sample_en   = 1'b1;
        tick_nxt    = '0;
        col_idx_nxt = col_idx + 1'b1;
        state_nxt   = (col_idx == 2'd3) ? ST_EVAL : ST_DRIVE;
      end
      ST_EVAL: begin
        eval_en   = 1'b1;
        tick_nxt  = TW'(1);
        state_nxt = ST_DRIVE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tick    <= '0;
      col_idx <= '0;
      col     <= COL_SEL[0];
    end else begin
      state   <= state_nxt;
      tick    <= tick_nxt;
      col_idx <= col_idx_nxt;
      col     <= COL_SEL[col_idx_nxt];
    end
  end

  // Lowest-numbered pressed row wins within a column
  always_comb begin
    hit     = 1'b0;
    hit_row = 2'd0;
    for (int j = ROWS - 1; j >= 0; j--) begin
      if (!row_sync[j]) begin
        hit     = 1'b1;
        hit_row = 2'(j);
      end
    end
  end

  // Column 0 starts a fresh scan; later columns only fill in if nothing was found yet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= KEY_NONE;
    end else if (sample_en && ((col_idx == 2'd0) || !cand.pressed)) begin
      cand <= hit ? key_t'({1'b1, KEYMAP[{hit_row, col_idx}]}) : KEY_NONE;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .eval      (eval_en),
    .cand      (cand),
    .key_code  (key_code),
    .key_strobe(key_strobe)
  );
endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: matrix model drives rows from the column outputs, strobes checked against a queue.
module tb_keypad_scanner;
  localparam int K5 = 1 * 4 + 1;
  localparam int K0 = 3 * 4 + 0;
  localparam int KF = 3 * 4 + 1;
  localparam int KD = 3 * 4 + 3;
  localparam int KA = 0 * 4 + 3;
  localparam int SCAN = 32;
  localparam int LAT  = 3 * SCAN + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [4:0]  key_code;
  logic        key_strobe;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_code;

  always #5 clk = ~clk;

  keypad_scanner #(
    .COL_TICKS(8),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_strobe(key_strobe)
  );

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Every strobe must match the oldest expected keycode
  always @(negedge clk) begin
    if (rst_n === 1'b1 && key_strobe === 1'b1) begin
      strobes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: key_code=%h, expected no strobe", key_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (key_code !== exp_code) begin
          errors++;
          $display("FAIL strobe_code: got %h, expected %h", key_code, exp_code);
        end
      end
    end
  end

  task automatic wait_code(input logic [4:0] code, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (key_code === code) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset(input logic [4:0] code_before);
    @(negedge clk);
    if (key_code !== code_before) begin
      errors++;
      $display("FAIL reset_pre_code: got %h, expected %h", key_code, code_before);
    end
    checks++;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (col !== 4'b1110) begin
      errors++;
      $display("FAIL reset_col: got %b, expected 1110", col);
    end
    checks++;
    if (key_code !== 5'h00) begin
      errors++;
      $display("FAIL reset_code: got %h, expected 00", key_code);
    end
    checks++;
    if (key_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobe: got %b, expected 0", key_strobe);
    end
    pressed = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_col_walk();
    logic [3:0] exp_col [4];
    int n;
    bit ok;
    exp_col = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (col === 4'b0111) begin
        ok = 1'b1;
        break;
      end
    end
    while (ok && col === 4'b0111) @(negedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL col_walk_start: col=%b, expected 0111 within 80 cycles", col);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (col !== exp_col[k]) begin
        errors++;
        $display("FAIL col_walk_value%0d: got %b, expected %b", k, col, exp_col[k]);
      end
      n = 0;
      while (col === exp_col[k] && n < 20) begin
        n++;
        @(negedge clk);
      end
      checks++;
      if (n != 8) begin
        errors++;
        $display("FAIL col_walk_len%0d: got %0d cycles, expected 8", k, n);
      end
    end
  endtask

  task automatic test_press();
    int s0;
    bit ok;
    s0 = strobes;
    exp_q.push_back(5'h15);
    pressed[K5] = 1'b1;
    wait_code(5'h15, LAT, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL press5_latency: key_code=%h, expected 15 within %0d cycles", key_code, LAT);
    end
    repeat (2 * SCAN) @(negedge clk);
    checks++;
    if (strobes - s0 != 1) begin
      errors++;
      $display("FAIL press5_strobes: got %0d, expected 1", strobes - s0);
    end
  endtask

  task automatic test_release();
    int s0;
    bit ok;
    s0 = strobes;
    pressed[K5] = 1'b0;
    wait_code(5'h05, LAT, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL release5: key_code=%h, expected 05 within %0d cycles", key_code, LAT);
    end
    repeat (2 * SCAN) @(negedge clk);
    checks++;
    if (strobes != s0) begin
      errors++;
      $display("FAIL release5_strobes: got %0d, expected 0", strobes - s0);
    end
    exp_q.push_back(5'h15);
    pressed[K5] = 1'b1;
    wait_code(5'h15, LAT, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL repress5: key_code=%h, expected 15 within %0d cycles", key_code, LAT);
    end
    repeat (2 * SCAN) @(negedge clk);
    checks++;
    if (strobes - s0 != 1) begin
      errors++;
      $display("FAIL repress5_strobes: got %0d, expected 1", strobes - s0);
    end
    pressed[K5] = 1'b0;
    wait_code(5'h05, LAT, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL release5_again: key_code=%h, expected 05", key_code);
    end
  endtask

  task automatic test_bounce();
    int s0;
    s0 = strobes;
    repeat (2 * SCAN) @(negedge clk);
    pressed[K0] = 1'b1;
    repeat (20) @(negedge clk);
    pressed[K0] = 1'b0;
    repeat (4 * SCAN) @(negedge clk);
    checks++;
    if (key_code !== 5'h05) begin
      errors++;
      $display("FAIL bounce_code: got %h, expected 05", key_code);
    end
    checks++;
    if (strobes != s0) begin
      errors++;
      $display("FAIL bounce_strobes: got %0d, expected 0", strobes - s0);
    end
  endtask

  task automatic test_rollover();
    int s0;
    bit ok;
    s0 = strobes;
    exp_q.push_back(5'h1A);
    pressed[KD] = 1'b1;
    pressed[KA] = 1'b1;
    wait_code(5'h1A, LAT, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL multi_key: key_code=%h, expected 1A within %0d cycles", key_code, LAT);
    end
    repeat (2 * SCAN) @(negedge clk);
    checks++;
    if (strobes - s0 != 1) begin
      errors++;
      $display("FAIL multi_key_strobes: got %0d, expected 1", strobes - s0);
    end
    exp_q.push_back(5'h1D);
    pressed[KA] = 1'b0;
    wait_code(5'h1D, LAT, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rollover: key_code=%h, expected 1D within %0d cycles", key_code, LAT);
    end
    repeat (2 * SCAN) @(negedge clk);
    checks++;
    if (strobes - s0 != 2) begin
      errors++;
      $display("FAIL rollover_strobes: got %0d, expected 2", strobes - s0);
    end
  endtask

  task automatic test_hold();
    int s0;
    bit ok;
    pressed = '0;
    wait_code(5'h0D, LAT, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL releaseD: key_code=%h, expected 0D within %0d cycles", key_code, LAT);
    end
    s0 = strobes;
    exp_q.push_back(5'h1F);
    pressed[KF] = 1'b1;
    repeat (50 * SCAN) @(negedge clk);
    checks++;
    if (key_code !== 5'h1F) begin
      errors++;
      $display("FAIL holdF_code: got %h, expected 1F", key_code);
    end
    checks++;
    if (strobes - s0 != 1) begin
      errors++;
      $display("FAIL holdF_strobes: got %0d, expected 1", strobes - s0);
    end
  endtask

  initial begin
    pressed = '0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (13) @(negedge clk);
    test_reset(5'h00);
    test_col_walk();
    test_press();
    test_release();
    test_bounce();
    test_rollover();
    test_hold();
    test_reset(5'h1F);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: %0d expected strobes never seen, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
